// File: rtl/irq_controller_multi.sv
// irq_controller_multi
//   Multi-channel interrupt controller for a 6502-style bus. N_CHANNELS sources
//   (1..32), each with its own enable and edge/level mode, are combined by fixed
//   priority (channel 0 highest) into a registered active-low IRQ line. An 8-bit
//   register window gives status/vector readout, EOI, and banked access to the
//   per-channel registers, eight channels per bank.
//
//   Ports:
//     clk     CPU clock, all state changes on the rising edge
//     rst_n   asynchronous active-low reset
//     cs      register window select
//     we      write strobe, qualified by cs
//     addr    register offset (0 STATUS, 1 BANK, 2 ENABLE, 3 EDGE_MODE,
//             4 PENDING, 5 RAW, 6..F reserved)
//     i_data  write data
//     o_data  combinational read data, 0 when cs is low
//     int_in  active-high interrupt sources
//     irqb    registered active-low IRQ to the CPU
//
//   Build option: define IRQ_CONTROLLER_SYNC_EN to pass int_in through a
//   2-flop synchroniser before edge detect, RAW readout and level capture.
module irq_controller_multi #(
   parameter int unsigned N_CHANNELS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  we,
   input  logic [3:0]            addr,
   input  logic [7:0]            i_data,
   output logic [7:0]            o_data,
   input  logic [N_CHANNELS-1:0] int_in,
   output logic                  irqb
);

   typedef logic [31:0] vec_t;

   // Channels that exist; every stored vector is kept zero outside this mask so
   // out-of-range bits and banks read back as 0 without extra read logic.
   localparam logic [32:0] MaskWide = (33'd1 << N_CHANNELS) - 33'd1;
   localparam vec_t        ChanMask = MaskWide[31:0];

   localparam logic [3:0] AddrStatus  = 4'h0;
   localparam logic [3:0] AddrBank    = 4'h1;
   localparam logic [3:0] AddrEnable  = 4'h2;
   localparam logic [3:0] AddrEdge    = 4'h3;
   localparam logic [3:0] AddrPending = 4'h4;
   localparam logic [3:0] AddrRaw     = 4'h5;

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic [N_CHANNELS-1:0] in_s;

`ifdef IRQ_CONTROLLER_SYNC_EN
   logic [N_CHANNELS-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= int_in;
         sync2_q <= sync1_q;
      end
   end

   assign in_s = sync2_q;
`else
   assign in_s = int_in;
`endif

   vec_t in_w;

   always_comb begin
      in_w                 = '0;
      in_w[N_CHANNELS-1:0] = in_s;
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   vec_t       enable_q, enable_d;
   vec_t       edge_q, edge_d;
   vec_t       pending_q, pending_d;
   vec_t       prev_q, prev_d;
   logic [1:0] bank_q, bank_d;
   logic       irqb_q, irqb_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q  <= '0;
         edge_q    <= '0;
         pending_q <= '0;
         prev_q    <= '0;
         bank_q    <= '0;
         irqb_q    <= 1'b1;
      end else begin
         enable_q  <= enable_d;
         edge_q    <= edge_d;
         pending_q <= pending_d;
         prev_q    <= prev_d;
         bank_q    <= bank_d;
         irqb_q    <= irqb_d;
      end
   end

   assign irqb = irqb_q;

   // ---------------------------------------------------------------------------
   // Write decode and next state
   // ---------------------------------------------------------------------------
   logic [4:0] base;
   logic       wr;
   vec_t       bank_wmask, bank_wdata;
   vec_t       w1c, eoi, clr, rise;

   assign base = {bank_q, 3'b000};
   assign wr   = cs & we;

   always_comb begin
      enable_d   = enable_q;
      edge_d     = edge_q;
      bank_d     = bank_q;
      bank_wmask = {24'd0, 8'hFF} << base;
      bank_wdata = {24'd0, i_data} << base;
      w1c        = '0;
      eoi        = '0;

      if (wr && addr == AddrBank) begin
         bank_d = i_data[1:0];
      end
      if (wr && addr == AddrEnable) begin
         enable_d = ((enable_q & ~bank_wmask) | bank_wdata) & ChanMask;
      end
      if (wr && addr == AddrEdge) begin
         edge_d = ((edge_q & ~bank_wmask) | bank_wdata) & ChanMask;
      end
      if (wr && addr == AddrPending) begin
         w1c = bank_wdata;
      end
      // EOI ids beyond N_CHANNELS fall outside ChanMask and have no effect.
      if (wr && addr == AddrStatus) begin
         eoi = vec_t'(1) << i_data[4:0];
      end

      clr  = w1c | eoi;
      rise = in_w & ~prev_q;

      // Edge channels: a new rise beats a same-cycle clear.
      // Level channels: pending simply tracks the (conditioned) input.
      pending_d = ((edge_q & (rise | (pending_q & ~clr))) | (~edge_q & in_w)) & ChanMask;
      prev_d    = in_w & ChanMask;
      irqb_d    = ~|(pending_q & enable_q);
   end

   // ---------------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------------
   vec_t       active;
   logic [4:0] active_id;
   vec_t       en_sh, edge_sh, pend_sh, raw_sh;

   assign active = pending_q & enable_q;

   // Scan downwards so the lowest-index active channel wins.
   always_comb begin
      active_id = '0;
      for (int i = 31; i >= 0; i--) begin
         if (active[i]) begin
            active_id = 5'(i);
         end
      end
   end

   assign en_sh   = enable_q >> base;
   assign edge_sh = edge_q >> base;
   assign pend_sh = pending_q >> base;
   assign raw_sh  = (in_w & ChanMask) >> base;

   always_comb begin
      o_data = 8'h00;
      if (cs) begin
         case (addr)
            AddrStatus:  o_data = (|active) ? {1'b1, 2'b00, active_id} : 8'h00;
            AddrBank:    o_data = {6'd0, bank_q};
            AddrEnable:  o_data = en_sh[7:0];
            AddrEdge:    o_data = edge_sh[7:0];
            AddrPending: o_data = pend_sh[7:0];
            AddrRaw:     o_data = raw_sh[7:0];
            default:     o_data = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_controller_multi.sv
// Directed self-checking bench for irq_controller_multi, built with 20 channels
// so that bank 0 exercises the 8-channel behaviour and bank 2/3 exercise the
// partial and out-of-range banks.
module tb_irq_controller_multi;

`ifdef IRQ_CONTROLLER_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   localparam int unsigned N = 20;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cs;
   logic         we;
   logic [3:0]   addr;
   logic [7:0]   i_data;
   logic [7:0]   o_data;
   logic [N-1:0] int_in;
   logic         irqb;

   int n_cmp = 0;
   int n_err = 0;

   irq_controller_multi #(
      .N_CHANNELS(N)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (cs),
      .we    (we),
      .addr  (addr),
      .i_data(i_data),
      .o_data(o_data),
      .int_in(int_in),
      .irqb  (irqb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 ns past the last edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cs     = 1'b1;
      we     = 1'b1;
      addr   = a;
      i_data = d;
      tick(1);
      cs     = 1'b0;
      we     = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
      cs   = 1'b1;
      we   = 1'b0;
      addr = a;
      #1;
      check(tag, {24'd0, o_data}, {24'd0, exp});
      cs   = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      cs     = 1'b0;
      we     = 1'b0;
      addr   = '0;
      i_data = '0;
      int_in = '0;

      // Reset held with inputs toggling
      for (int i = 0; i < 4; i++) begin
         int_in = (i % 2 == 0) ? 20'hFFFFF : 20'h0;
         tick(1);
      end
      int_in = '0;
      #1;
      check("rst_irqb", {31'd0, irqb}, 32'd1);
      check("rst_odata_cs_low", {24'd0, o_data}, 32'd0);
      for (int a = 0; a < 6; a++) begin
         rd("rst_reg", 4'(a), 8'h00);
      end
      rst_n = 1'b1;
      tick(1);
      rd("post_rst_bank", 4'h1, 8'h00);
      rd("post_rst_status", 4'h0, 8'h00);

      // Edge source on channel 3
      wr(4'h2, 8'h08);
      wr(4'h3, 8'h08);
      int_in[3] = 1'b1;
      tick(1);
      int_in[3] = 1'b0;
      tick(S);
      check("edge_irqb_not_yet", {31'd0, irqb}, 32'd1);
      tick(1);
      check("edge_irqb_low", {31'd0, irqb}, 32'd0);
      rd("edge_status", 4'h0, 8'h83);
      rd("edge_pending", 4'h4, 8'h08);
      wr(4'h0, 8'h03);
      rd("edge_pending_after_eoi", 4'h4, 8'h00);
      tick(1);
      check("edge_irqb_release", {31'd0, irqb}, 32'd1);

      // Priority between channels 2 and 5
      wr(4'h2, 8'hFF);
      wr(4'h3, 8'hFF);
      int_in[5] = 1'b1;
      int_in[2] = 1'b1;
      tick(2 + S);
      check("prio_irqb_low", {31'd0, irqb}, 32'd0);
      rd("prio_status_2", 4'h0, 8'h82);
      wr(4'h0, 8'h02);
      rd("prio_status_5", 4'h0, 8'h85);
      tick(1);
      check("prio_irqb_held", {31'd0, irqb}, 32'd0);
      wr(4'h0, 8'h05);
      tick(1);
      check("prio_irqb_release", {31'd0, irqb}, 32'd1);
      int_in = '0;
      tick(1 + S);

      // Level source on channel 0
      wr(4'h3, 8'hFE);
      wr(4'h2, 8'h01);
      int_in[0] = 1'b1;
      tick(2 + S);
      check("lvl_irqb_low", {31'd0, irqb}, 32'd0);
      wr(4'h0, 8'h00);
      tick(1);
      check("lvl_irqb_after_eoi", {31'd0, irqb}, 32'd0);
      wr(4'h4, 8'h01);
      rd("lvl_pending_after_w1c", 4'h4, 8'h01);
      tick(1);
      check("lvl_irqb_after_w1c", {31'd0, irqb}, 32'd0);
      int_in[0] = 1'b0;
      tick(1 + S);
      check("lvl_irqb_drop_early", {31'd0, irqb}, 32'd0);
      tick(1);
      check("lvl_irqb_release", {31'd0, irqb}, 32'd1);

      // Masking and banking with channel 17
      wr(4'h1, 8'h00);
      wr(4'h2, 8'h00);
      wr(4'h1, 8'h01);
      wr(4'h2, 8'h00);
      wr(4'h1, 8'h02);
      wr(4'h2, 8'h00);
      wr(4'h3, 8'hFF);
      rd("bank2_edge_masked", 4'h3, 8'h0F);
      int_in[17] = 1'b1;
      tick(2 + S);
      check("mask_irqb_high", {31'd0, irqb}, 32'd1);
      rd("bank2_pending", 4'h4, 8'h02);
      rd("bank2_raw", 4'h5, 8'h02);
      wr(4'h2, 8'h02);
      tick(1);
      check("mask_irqb_low", {31'd0, irqb}, 32'd0);
      rd("bank2_status", 4'h0, 8'h91);
      rd("bank_readback", 4'h1, 8'h02);
      wr(4'h0, 8'h19);
      rd("eoi_out_of_range", 4'h0, 8'h91);
      wr(4'h1, 8'hFF);
      rd("bank_bits", 4'h1, 8'h03);
      for (int a = 2; a < 6; a++) begin
         rd("bank3_zero", 4'(a), 8'h00);
      end
      rd("reserved_addr", 4'h9, 8'h00);
      wr(4'h0, 8'h11);
      int_in[17] = 1'b0;
      tick(2 + S);
      check("bank2_irqb_release", {31'd0, irqb}, 32'd1);

      // Set/clear collision on channel 1
      wr(4'h1, 8'h00);
      wr(4'h2, 8'h02);
      wr(4'h3, 8'h02);
      int_in[1] = 1'b1;
      tick(1 + S);
      rd("coll_pending_set", 4'h4, 8'h02);
      int_in[1] = 1'b0;
      tick(1 + S);
      int_in[1] = 1'b1;
      tick(S);
      wr(4'h4, 8'h02);
      rd("coll_set_wins", 4'h4, 8'h02);
      int_in[1] = 1'b0;
      tick(1 + S);
      wr(4'h4, 8'h02);
      rd("coll_plain_w1c", 4'h4, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
